// File: rtl/shr.sv
// Shift register for the Wishbone-SPI data path: loads a byte from the bus,
// shifts it out on dout while capturing din, and always exposes the word on dstr.
module shr #(
  parameter int WIDTH     = 8,   // must be >= 2
  parameter int LSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             sh,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_data,
  output logic             dout,
  output logic [WIDTH-1:0] dstr
);

  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] shifted;

  // din enters at the end opposite dout, so dout always shows the next bit to send
  generate
    if (LSB_FIRST != 0) begin : g_lsb
      assign shifted = {din, r[WIDTH-1:1]};
      assign dout    = r[0];
    end else begin : g_msb
      assign shifted = {r[WIDTH-2:0], din};
      assign dout    = r[WIDTH-1];
    end
  endgenerate

  // Load wins over shift; din is only sampled when a shift actually happens
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r <= '0;
    end else if (ld) begin
      r <= ld_data;
    end else if (sh) begin
      r <= shifted;
    end
  end

  assign dstr = r;

endmodule

// File: tb/tb_shr.sv
// Directed bench for shr: drivers push expected {dstr,dout} into a queue,
// an independent monitor pops and compares on the falling edge.
module tb_shr;

  localparam int W = 10;  // {dut select, dout, dstr[7:0]}

  logic       clk;
  logic       rst;
  logic       din_a, sh_a, ld_a;
  logic [7:0] ld_data_a;
  logic       dout_a;
  logic [7:0] dstr_a;
  logic       din_b, sh_b, ld_b;
  logic [7:0] ld_data_b;
  logic       dout_b;
  logic [7:0] dstr_b;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_tests;
  int           n_fail;
  event         async_ev;

  shr #(.WIDTH(8), .LSB_FIRST(0)) dut_a (
    .clk(clk), .rst(rst), .din(din_a), .sh(sh_a), .ld(ld_a),
    .ld_data(ld_data_a), .dout(dout_a), .dstr(dstr_a)
  );

  shr #(.WIDTH(8), .LSB_FIRST(1)) dut_b (
    .clk(clk), .rst(rst), .din(din_b), .sh(sh_b), .ld(ld_b),
    .ld_data(ld_data_b), .dout(dout_b), .dstr(dstr_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard monitor
  always @(negedge clk or async_ev) begin
    while (exp_q.size() > 0) begin
      logic [W-1:0] e;
      string        nm;
      logic         act_dout;
      logic [7:0]   act_dstr;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      act_dout = e[9] ? dout_b : dout_a;
      act_dstr = e[9] ? dstr_b : dstr_a;
      n_tests++;
      if (act_dout !== e[8] || act_dstr !== e[7:0]) begin
        n_fail++;
        $display("FAIL %s: got dstr=%h dout=%b, expected dstr=%h dout=%b",
                 nm, act_dstr, act_dout, e[7:0], e[8]);
      end
    end
  end

  // driver: one clock edge on the selected DUT, then queue the expected result
  task automatic cyc(input bit b, input bit ldv, input bit shv, input bit dinv,
                     input bit loop, input logic [7:0] data,
                     input logic [7:0] e_dstr, input bit e_dout, input string nm);
    @(negedge clk);
    if (b) begin
      ld_b = ldv; sh_b = shv; din_b = loop ? dout_b : dinv; ld_data_b = data;
    end else begin
      ld_a = ldv; sh_a = shv; din_a = loop ? dout_a : dinv; ld_data_a = data;
    end
    @(posedge clk);
    #1;
    ld_a = 1'b0; sh_a = 1'b0; ld_b = 1'b0; sh_b = 1'b0;
    exp_q.push_back({b, e_dout, e_dstr});
    name_q.push_back(nm);
  endtask

  logic [7:0] a5_dstr[8];
  logic [7:0] loop_dstr[8];
  logic [7:0] v;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b0;
    din_a = 1'b0; sh_a = 1'b0; ld_a = 1'b0; ld_data_a = 8'h00;
    din_b = 1'b0; sh_b = 1'b0; ld_b = 1'b0; ld_data_b = 8'h00;
    a5_dstr   = '{8'h4A, 8'h94, 8'h28, 8'h50, 8'hA0, 8'h40, 8'h80, 8'h00};
    loop_dstr = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};

    // 1. reset holds R at zero despite ld=1
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 8'hFF, 8'h00, 1'b0, "reset_hold");
    @(negedge clk);
    rst = 1'b1;
    cyc(0, 1, 0, 0, 0, 8'hFF, 8'hFF, 1'b1, "first_load");

    // 2. load A5 and shift out MSB first
    cyc(0, 1, 0, 0, 0, 8'hA5, 8'hA5, 1'b1, "load_a5");
    for (int k = 0; k < 8; k++)
      cyc(0, 0, 1, 0, 0, 8'h00, a5_dstr[k], a5_dstr[k][7], "shift_a5");

    // 3. load n, then 7 shifts doubling the value
    for (int n = 1; n <= 3; n++) begin
      v = 8'(n);
      cyc(0, 1, 0, 0, 0, v, v, v[7], "bench_load");
      for (int k = 1; k <= 7; k++) begin
        v = 8'((n << k) & 8'hFF);
        cyc(0, 0, 1, 0, 0, 8'h00, v, v[7], "bench_shift");
      end
    end

    // 4. loopback rotation
    cyc(0, 1, 0, 0, 0, 8'h81, 8'h81, 1'b1, "loop_load");
    for (int k = 0; k < 8; k++)
      cyc(0, 0, 1, 0, 1, 8'h00, loop_dstr[k], loop_dstr[k][7], "loop_shift");

    // 5. load beats shift, then hold with din toggling
    cyc(0, 1, 1, 1, 0, 8'h3C, 8'h3C, 1'b0, "ld_over_sh");
    for (int k = 0; k < 5; k++)
      cyc(0, 0, 0, k[0], 0, 8'hFF, 8'h3C, 1'b0, "hold");

    // 6a. three shifts with din=1, then async reset between edges
    cyc(0, 0, 1, 1, 0, 8'h00, 8'h79, 1'b0, "pre_rst_shift1");
    cyc(0, 0, 1, 1, 0, 8'h00, 8'hF3, 1'b1, "pre_rst_shift2");
    cyc(0, 0, 1, 1, 0, 8'h00, 8'hE7, 1'b1, "pre_rst_shift3");
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    exp_q.push_back({1'b0, 1'b0, 8'h00});
    name_q.push_back("async_rst");
    -> async_ev;
    #1 rst = 1'b1;
    cyc(0, 0, 0, 0, 0, 8'h00, 8'h00, 1'b0, "after_rst");

    // 6b. LSB-first instance
    cyc(1, 1, 0, 0, 0, 8'h01, 8'h01, 1'b1, "lsb_load01");
    cyc(1, 0, 1, 1, 0, 8'h00, 8'h80, 1'b0, "lsb_shift_din1");
    cyc(1, 0, 1, 0, 0, 8'h00, 8'h40, 1'b0, "lsb_shift_din0");
    cyc(1, 1, 0, 0, 0, 8'hA5, 8'hA5, 1'b1, "lsb_load_a5");
    cyc(1, 0, 1, 0, 0, 8'h00, 8'h52, 1'b0, "lsb_shift_a5");
    cyc(1, 0, 1, 1, 0, 8'h00, 8'hA9, 1'b1, "lsb_shift_a5_din1");

    // drain scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
